// File: rtl/mat_pkg.sv
// Purpose: shared operand geometry, loader FSM encoding and counter-width helper.
// Latency: none (types and constants only).
// Backpressure: n/a.
// Contents: default A_ROWS/A_COLS/B_COLS shared with the GF(2) multiplier,
//           loader_state_t {LOAD_A, LOAD_B, HOLD}, and cnt_w() for counter widths.
package mat_pkg;

    localparam int A_ROWS_DEF = 4;
    localparam int A_COLS_DEF = 8;
    localparam int B_COLS_DEF = 1;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } loader_state_t;

    // Width of a counter spanning 0..n-1. A single-entry counter still gets one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mat_loader.sv
// Purpose: assemble matrices A and B from a framed word stream for the GF(2) multiplier.
// Latency: out_valid rises the cycle after the last B beat; one bubble cycle after out_ready.
// Backpressure: in_ready drops while a complete A/B pair is held for out_ready.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_sof/in_data input stream;
//        A_data_out/B_data_out packed operand buses; out_valid/out_ready output handshake;
//        err one-cycle framing-error pulse.
// Option: MAT_LOADER_REUSE_A_EN adds keep_a; a sof beat with keep_a=1 (after a frame has
//         loaded) is taken as B column 0 and the previous A is retained.
module mat_loader
    import mat_pkg::*;
#(
    parameter int A_ROWS = A_ROWS_DEF,
    parameter int A_COLS = A_COLS_DEF,
    parameter int B_COLS = B_COLS_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sof,
    input  logic [A_COLS-1:0]          in_data,
    output logic [A_ROWS*A_COLS-1:0]   A_data_out,
    output logic [A_COLS*B_COLS-1:0]   B_data_out,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef MAT_LOADER_REUSE_A_EN
    input  logic                       keep_a,
`endif
    output logic                       err
);

    localparam int RW = cnt_w(A_ROWS);
    localparam int CW = cnt_w(B_COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(A_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(B_COLS - 1);
    // A one-row A is complete after the sof beat alone.
    localparam loader_state_t AFTER_ROW0 = (A_ROWS == 1) ? LOAD_B : LOAD_A;
    localparam logic [RW-1:0] ROW_AFTER0 = (A_ROWS == 1) ? '0 : RW'(1);

    loader_state_t                  r_state;
    logic [RW-1:0]                  r_row_cnt;
    logic [CW-1:0]                  r_col_cnt;
    logic [A_ROWS-1:0][A_COLS-1:0]  r_a;
    logic [A_COLS-1:0][B_COLS-1:0]  r_b;
    logic                           r_err;

    logic w_beat;
    logic w_row0;
    logic w_reuse;

    assign w_beat = in_valid & in_ready;
    assign w_row0 = (r_state == LOAD_A) && (r_row_cnt == '0);

`ifdef MAT_LOADER_REUSE_A_EN
    // Set once a full frame has reached HOLD; A is only reusable after that.
    logic r_loaded;
    assign w_reuse = keep_a & r_loaded;
`else
    assign w_reuse = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= LOAD_A;
            r_row_cnt <= '0;
            r_col_cnt <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_err     <= 1'b0;
`ifdef MAT_LOADER_REUSE_A_EN
            r_loaded  <= 1'b0;
`endif
        end else begin
            r_err <= 1'b0;
            if (r_state == HOLD) begin
                if (out_ready) begin
                    r_state   <= LOAD_A;
                    r_row_cnt <= '0;
                    r_col_cnt <= '0;
                end
            end else if (w_beat) begin
                if (in_sof) begin
                    // A sof anywhere but the frame start restarts the frame and flags it.
                    r_err     <= ~w_row0;
                    r_row_cnt <= '0;
                    if (w_reuse) begin
                        for (int i = 0; i < A_COLS; i++) r_b[i][0] <= in_data[i];
                        if (B_COLS == 1) begin
                            r_state   <= HOLD;
                            r_col_cnt <= '0;
`ifdef MAT_LOADER_REUSE_A_EN
                            r_loaded  <= 1'b1;
`endif
                        end else begin
                            r_state   <= LOAD_B;
                            r_col_cnt <= CW'(1);
                        end
                    end else begin
                        r_a[0]    <= in_data;
                        r_row_cnt <= ROW_AFTER0;
                        r_col_cnt <= '0;
                        r_state   <= AFTER_ROW0;
                    end
                end else if (w_row0) begin
                    // Frame start without sof: drop the word.
                    r_err <= 1'b1;
                end else if (r_state == LOAD_A) begin
                    r_a[r_row_cnt] <= in_data;
                    if (r_row_cnt == ROW_LAST) begin
                        r_row_cnt <= '0;
                        r_state   <= LOAD_B;
                    end else begin
                        r_row_cnt <= r_row_cnt + 1'b1;
                    end
                end else begin
                    for (int i = 0; i < A_COLS; i++) r_b[i][r_col_cnt] <= in_data[i];
                    if (r_col_cnt == COL_LAST) begin
                        r_col_cnt <= '0;
                        r_state   <= HOLD;
`ifdef MAT_LOADER_REUSE_A_EN
                        r_loaded  <= 1'b1;
`endif
                    end else begin
                        r_col_cnt <= r_col_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign in_ready   = (r_state != HOLD);
    assign out_valid  = (r_state == HOLD);
    assign A_data_out = r_a;
    assign B_data_out = r_b;
    assign err        = r_err;

endmodule

// File: tb/tb_mat_loader.sv
module tb_mat_loader;
    import mat_pkg::*;

    localparam int AR    = 4;
    localparam int AC    = 8;
    localparam int BC    = 1;
    localparam int HOLDP = AR + BC;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sof;
    logic [AC-1:0]        in_data;
    logic [AR*AC-1:0]     A_data_out;
    logic [AC*BC-1:0]     B_data_out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 keep_a;
    logic                 err;

    always #5 clk = ~clk;

    mat_loader #(.A_ROWS(AR), .A_COLS(AC), .B_COLS(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .A_data_out (A_data_out),
        .B_data_out (B_data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef MAT_LOADER_REUSE_A_EN
        .keep_a     (keep_a),
`endif
        .err        (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: position within the frame (0..AR-1 A rows, AR..AR+BC-1 B columns,
    // HOLDP = complete), plus the matrices as arrays of words.
    int            m_pos;
    logic [AC-1:0] m_a [AR];
    logic [AC-1:0] m_b [BC];
    bit            m_err;
    bit            m_loaded;

    task automatic model_step();
        bit reuse;
        reuse = 1'b0;
        if (rst) begin
            m_pos = 0; m_err = 0; m_loaded = 0;
            for (int r = 0; r < AR; r++) m_a[r] = '0;
            for (int k = 0; k < BC; k++) m_b[k] = '0;
        end else begin
            m_err = 0;
`ifdef MAT_LOADER_REUSE_A_EN
            reuse = keep_a && m_loaded;
`endif
            if (m_pos == HOLDP) begin
                if (out_ready) m_pos = 0;
            end else if (in_valid) begin
                if (in_sof) begin
                    m_err = (m_pos != 0);
                    if (reuse) begin
                        m_b[0] = in_data;
                        m_pos  = AR + 1;
                        if (m_pos == HOLDP) m_loaded = 1;
                    end else begin
                        m_a[0] = in_data;
                        m_pos  = 1;
                    end
                end else if (m_pos == 0) begin
                    m_err = 1;
                end else if (m_pos < AR) begin
                    m_a[m_pos] = in_data;
                    m_pos++;
                end else begin
                    m_b[m_pos-AR] = in_data;
                    m_pos++;
                    if (m_pos == HOLDP) m_loaded = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [AR*AC-1:0] ea;
        logic [AC*BC-1:0] eb;
        for (int r = 0; r < AR; r++) ea[r*AC +: AC] = m_a[r];
        for (int i = 0; i < AC; i++)
            for (int k = 0; k < BC; k++) eb[i*BC+k] = m_b[k][i];
        chk("out_valid", 64'(out_valid), 64'(m_pos == HOLDP));
        chk("in_ready",  64'(in_ready),  64'(m_pos != HOLDP));
        chk("err",       64'(err),       64'(m_err));
        chk("A_data",    64'(A_data_out), 64'(ea));
        chk("B_data",    64'(B_data_out), 64'(eb));
    endtask

    // Drive one cycle of inputs (at the falling edge), advance the model, check after the edge.
    task automatic cyc(input bit v, input bit s, input logic [AC-1:0] d,
                       input bit ordy, input bit r, input bit k = 1'b0);
        in_valid  = v;
        in_sof    = s;
        in_data   = d;
        out_ready = ordy;
        rst       = r;
        keep_a    = k;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        out_ready = 1'b0; keep_a = 1'b0;
        cyc(0, 0, 8'h00, 0, 1);
        cyc(0, 0, 8'h00, 0, 1);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_A", 64'(A_data_out), 64'd0);

        // Basic frame.
        cyc(1, 1, 8'h81, 0, 0);
        cyc(1, 0, 8'h42, 0, 0);
        cyc(1, 0, 8'h24, 0, 0);
        cyc(1, 0, 8'h18, 0, 0);
        cyc(1, 0, 8'hFF, 0, 0);
        chk("frame1_valid", 64'(out_valid), 64'd1);
        chk("frame1_A", 64'(A_data_out), 64'h18244281);
        chk("frame1_B", 64'(B_data_out), 64'hFF);
        chk("frame1_ready", 64'(in_ready), 64'd0);

        // Wait on out_ready with in_valid asserted: everything frozen.
        for (int i = 0; i < 10; i++) begin
            cyc(1, i[0], 8'($urandom), 0, 0);
            chk("hold_A", 64'(A_data_out), 64'h18244281);
        end
        cyc(0, 0, 8'h00, 1, 0);
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_ready", 64'(in_ready), 64'd1);

        // First beat without sof is dropped.
        cyc(1, 0, 8'hAA, 0, 0);
        chk("nosof_err", 64'(err), 64'd1);

        // Mid-frame sof restarts the frame.
        cyc(1, 1, 8'h01, 0, 0);
        cyc(1, 0, 8'h02, 0, 0);
        cyc(1, 0, 8'h03, 0, 0);
        cyc(1, 1, 8'h11, 0, 0);
        chk("midsof_err", 64'(err), 64'd1);
        chk("midsof_row0", 64'(A_data_out[7:0]), 64'h11);
        cyc(1, 0, 8'h22, 0, 0);
        cyc(1, 0, 8'h33, 0, 0);
        cyc(1, 0, 8'h44, 0, 0);
        cyc(1, 0, 8'h5A, 0, 0);
        chk("restart_valid", 64'(out_valid), 64'd1);
        chk("restart_A", 64'(A_data_out), 64'h44332211);
        cyc(0, 0, 8'h00, 1, 0);

`ifdef MAT_LOADER_REUSE_A_EN
        cyc(1, 1, 8'h0F, 0, 0, 1);
        chk("reuse_valid", 64'(out_valid), 64'd1);
        chk("reuse_A", 64'(A_data_out), 64'h44332211);
        chk("reuse_B", 64'(B_data_out), 64'h0F);
        cyc(0, 0, 8'h00, 1, 0);
`endif

        // Reset while in LOAD_B.
        cyc(1, 1, 8'hC1, 0, 0);
        cyc(1, 0, 8'hC2, 0, 0);
        cyc(1, 0, 8'hC3, 0, 0);
        cyc(1, 0, 8'hC4, 0, 0);
        cyc(0, 0, 8'h00, 0, 1);
        chk("rstB_valid", 64'(out_valid), 64'd0);
        chk("rstB_A", 64'(A_data_out), 64'd0);
        chk("rstB_B", 64'(B_data_out), 64'd0);
        chk("rstB_ready", 64'(in_ready), 64'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit v, s, o, r, k;
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 7) == 0) || (m_pos == 0 && $urandom_range(0, 3) != 0);
            o = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 249) == 0);
            k = ($urandom_range(0, 2) == 0);
            cyc(v, s, 8'($urandom), o, r, k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mat_loader.md
Name: mat_loader

Overview:
Upstream feeder for the GF(2) matrix multiplier. Accepts a framed stream of A_COLS-bit words over a valid/ready handshake and assembles matrix A (A_ROWS x A_COLS) and matrix B (A_COLS x B_COLS). Presents both as packed 2-D buses with a valid/ready output handshake. The multiplier consumes these directly; the bus layouts match its A_data_in and B_data_in ports.

Parameters:
A_ROWS, 4, rows of A (and of C)
A_COLS, 8, columns of A = rows of B = input word width
B_COLS, 1, columns of B (and of C)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  loader can accept a word
in_sof  in  1  marks first word of a frame; qualified by in_valid
in_data  in  A_COLS  A row (bit c = A[r][c]) or B column (bit i = B[i][k])
A_data_out  out  A_ROWS*A_COLS  packed [A_ROWS-1:0][A_COLS-1:0]; A[r][c] at bit r*A_COLS+c
B_data_out  out  A_COLS*B_COLS  packed [A_COLS-1:0][B_COLS-1:0]; B[i][k] at bit i*B_COLS+k
out_valid  out  1  A/B complete and stable
out_ready  in  1  multiplier accepts the operands
err  out  1  one-cycle pulse on framing error

Behaviour:
- Beat = in_valid & in_ready. Frame = A_ROWS beats of A rows (row 0 first), then B_COLS beats of B columns (col 0 first).
- FSM states LOAD_A, LOAD_B, HOLD. Counters: row_cnt (0..A_ROWS-1), col_cnt (0..B_COLS-1).
- LOAD_A: in_ready=1. Each beat writes row row_cnt and increments it. The beat at row_cnt=A_ROWS-1 moves the FSM to LOAD_B.
- LOAD_B: in_ready=1. Each beat writes B column col_cnt and increments it. The beat at col_cnt=B_COLS-1 moves the FSM to HOLD.
- HOLD: in_ready=0, out_valid=1. A_data_out and B_data_out stay frozen. out_ready=1 returns the FSM to LOAD_A with both counters cleared; in_ready is high on the next cycle (1-cycle bubble).
- Latency: out_valid rises on the cycle after the last B beat.
- out_valid may wait indefinitely for out_ready. Outputs do not change while waiting.
- Framing, first beat: a beat at LOAD_A with row_cnt=0 and in_sof=0 is dropped, err pulses, and the FSM stays put.
- Framing, mid-frame: a beat with in_sof=1 at any position other than LOAD_A row 0 discards the partial frame. That beat is written as A row 0, row_cnt becomes 1, col_cnt becomes 0, the FSM goes to LOAD_A, and err pulses.
- When A_ROWS=1, the single sof beat goes straight to LOAD_B.
- Partially loaded data is visible on the outputs but not valid; consumers honour out_valid only.
- Reset (at any time, including mid-frame or in HOLD):
  - state=LOAD_A, counters=0
  - A_data_out=0, B_data_out=0
  - out_valid=0, err=0
  - in_ready=1 from the first cycle after rst deasserts.

Optional Feature:
Macro MAT_LOADER_REUSE_A_EN.
- Defined:
  - Adds input port keep_a (1 bit), sampled on the sof beat.
  - keep_a=1 with at least one frame loaded since reset: the sof beat is treated as B column 0, A is retained, and the FSM enters LOAD_B (or HOLD if B_COLS=1).
  - keep_a=1 before any frame has loaded: ignored, with no err pulse.
- Undefined: no keep_a port; every frame carries A.

Decomposition:
- Package mat_pkg holds:
  - default A_ROWS/A_COLS/B_COLS localparams shared with the multiplier
  - the loader_state_t enum {LOAD_A, LOAD_B, HOLD}
  - width helpers for counter widths ($clog2 with a minimum of 1).
- No sub-module: FSM, counters and operand registers live in one module.

Test Plan:
All cases use defaults (4, 8, 1).
- Reset release, then send sof+8'h81, 8'h42, 8'h24, 8'h18, then B 8'hFF -> out_valid on the cycle after the B beat; A_data_out=32'h18244281, B_data_out=8'hFF; in_ready=0.
- Hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_valid ignored. Then out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
- First beat without in_sof (8'hAA) -> err pulse, word dropped. The next sof frame loads normally.
- Send sof+3 A rows, then sof+8'h11 -> err pulse, row_cnt=1, A row 0=8'h11. Completing 3 rows plus B gives a valid frame.
- Assert rst in LOAD_B with 4 rows loaded -> the next cycle has out_valid=0, A/B outputs=0, in_ready=1.
- With MAT_LOADER_REUSE_A_EN: after frame 1, send sof+keep_a=1+8'h0F -> out_valid with A unchanged and B_data_out=8'h0F.
